// File: rtl/raw_scoreboard.sv
// rtl/raw_scoreboard.sv - RAW hazard scoreboard for a four-slot in-order pipeline.
// Tracks pending register writes per stage and stalls decode on unresolvable reads.
module raw_scoreboard (
  input  logic       clk,
  input  logic       reset,
  input  logic       adv,
  input  logic       flush,
  input  logic       id_valid,
  input  logic       id_we,
  input  logic [2:0] id_rd,
  input  logic [2:0] id_rs1,
  input  logic [2:0] id_rs2,
  input  logic       id_use1,
  input  logic       id_use2,
  output logic       stall,
  output logic [2:0] register_invalid [7:0],
  output logic       wb_en,
  output logic [2:0] wb_wr
);

  typedef struct packed {
    logic       valid;
    logic       we;
    logic [2:0] rd;
  } slot_t;

  slot_t s1, s2, s3, s4;
  logic  issue;
  logic  hazard1, hazard2;

  // Oldest slot written first so younger matches override it.
  always_comb begin
    for (int r = 0; r < 8; r++) begin
      register_invalid[r] = 3'd0;
      if (s4.valid && s4.we && s4.rd == 3'(r)) register_invalid[r] = 3'd4;
      if (s3.valid && s3.we && s3.rd == 3'(r)) register_invalid[r] = 3'd3;
      if (s2.valid && s2.we && s2.rd == 3'(r)) register_invalid[r] = 3'd2;
      if (s1.valid && s1.we && s1.rd == 3'(r)) register_invalid[r] = 3'd1;
    end
  end

  // Stage 4 is bypassed from writeback data, so only stages 1..3 block a read.
  always_comb begin
    hazard1 = (register_invalid[id_rs1] != 3'd0) && (register_invalid[id_rs1] != 3'd4);
    hazard2 = (register_invalid[id_rs2] != 3'd0) && (register_invalid[id_rs2] != 3'd4);
    stall   = id_valid && ((id_use1 && hazard1) || (id_use2 && hazard2));
    issue   = adv && id_valid && !stall && !flush;
    wb_en   = s4.valid && s4.we && adv;
    wb_wr   = s4.rd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      s4 <= '0;
    end else if (flush) begin
      if (adv) begin
        s1 <= '0;
        s2 <= '0;
        s3 <= '0;
        s4 <= s3;
      end else begin
        s1.valid <= 1'b0;
        s2.valid <= 1'b0;
      end
    end else if (adv) begin
      s1 <= issue ? slot_t'{valid: 1'b1, we: id_we, rd: id_rd} : slot_t'('0);
      s2 <= s1;
      s3 <= s2;
      s4 <= s3;
    end
  end

endmodule

// File: tb/tb_raw_scoreboard.sv
// tb/tb_raw_scoreboard.sv - bench for raw_scoreboard.
// Reference model tracks in-flight writes by age rather than by slot registers.
module tb_raw_scoreboard;

  logic       clk = 1'b0;
  logic       reset, adv, flush, id_valid, id_we, id_use1, id_use2;
  logic [2:0] id_rd, id_rs1, id_rs2;
  logic       stall, wb_en;
  logic [2:0] wb_wr;
  logic [2:0] ri [7:0];

  int total = 0;
  int bad = 0;

  int q_age[$];
  int q_rd[$];
  logic last_stall, last_wb;
  logic [2:0] last_wr;
  bit checking = 0;
  int cnt_a, cnt_b;

  always #5 clk = ~clk;

  raw_scoreboard dut (
    .clk(clk), .reset(reset), .adv(adv), .flush(flush),
    .id_valid(id_valid), .id_we(id_we), .id_rd(id_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
    .stall(stall), .register_invalid(ri), .wb_en(wb_en), .wb_wr(wb_wr)
  );

  function automatic int m_ri(int r);
    int best = 0;
    foreach (q_age[i])
      if (q_rd[i] == r && (best == 0 || q_age[i] < best)) best = q_age[i];
    return best;
  endfunction

  function automatic logic [23:0] m_pack();
    logic [23:0] v = '0;
    for (int r = 0; r < 8; r++) v[r*3 +: 3] = 3'(m_ri(r));
    return v;
  endfunction

  function automatic logic [23:0] dut_pack();
    logic [23:0] v = '0;
    for (int r = 0; r < 8; r++) v[r*3 +: 3] = ri[r];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic a, input logic f, input logic v,
                      input logic w, input logic [2:0] rd, input logic [2:0] rs1,
                      input logic [2:0] rs2, input logic u1, input logic u2);
    logic exp_stall, exp_wb, iss;
    int   k1, k2, wb_rd;
    int   na[$];
    int   nr[$];
    reset = r; adv = a; flush = f; id_valid = v; id_we = w;
    id_rd = rd; id_rs1 = rs1; id_rs2 = rs2; id_use1 = u1; id_use2 = u2;
    #2;
    k1 = m_ri(int'(rs1));
    k2 = m_ri(int'(rs2));
    exp_stall = v && ((u1 && k1 >= 1 && k1 <= 3) || (u2 && k2 >= 1 && k2 <= 3));
    exp_wb = 1'b0;
    wb_rd = 0;
    foreach (q_age[i]) if (q_age[i] == 4) begin exp_wb = a; wb_rd = q_rd[i]; end
    last_stall = stall;
    last_wb = wb_en;
    last_wr = wb_wr;
    if (checking) begin
      chk("ri", 32'(dut_pack()), 32'(m_pack()));
      chk("stall", 32'(stall), 32'(exp_stall));
      chk("wb_en", 32'(wb_en), 32'(exp_wb));
      if (exp_wb) chk("wb_wr", 32'(wb_wr), 32'(wb_rd));
    end
    iss = a && v && !exp_stall && !f;
    @(posedge clk);
    if (!r) begin
      foreach (q_age[i]) begin
        int age = q_age[i];
        if (f && age <= 2) continue;
        if (a) age++;
        if (age <= 4) begin na.push_back(age); nr.push_back(q_rd[i]); end
      end
      if (iss && w) begin na.push_back(1); nr.push_back(int'(rd)); end
    end
    q_age = na;
    q_rd = nr;
    if (r) checking = 1;
    #1;
  endtask

  task automatic idle(input logic a);
    step(1'b0, a, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [2:0] rd);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, rd, 3'd0, 3'd0, 1'b0, 1'b0);
  endtask

  initial begin
    // reset state
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    chk("rst_ri", 32'(dut_pack()), 32'd0);
    chk("rst_wb_en", 32'(wb_en), 32'd0);
    chk("rst_wb_wr", 32'(wb_wr), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);

    // single write walks through the pipeline
    wr(3'd3);
    chk("r3_age1", 32'(ri[3]), 32'd1);
    for (int k = 2; k <= 4; k++) begin
      idle(1'b1);
      chk("r3_age", 32'(ri[3]), 32'(k));
      chk("r3_no_wb", 32'(last_wb), 32'd0);
    end
    idle(1'b1);
    chk("r3_wb", 32'(last_wb), 32'd1);
    chk("r3_wr", 32'(last_wr), 32'd3);
    chk("r3_clear", 32'(ri[3]), 32'd0);

    // read-after-write stalls until the producer reaches writeback
    wr(3'd2);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 3'd2, 3'd0, 1'b1, 1'b0);
      chk("r2_stall", 32'(last_stall), 32'(k < 3));
    end
    repeat (4) idle(1'b1);

    // back-to-back writes to the same register
    cnt_a = 0;
    wr(3'd5);
    wr(3'd5);
    chk("r5_young", 32'(ri[5]), 32'd1);
    for (int k = 2; k <= 6; k++) begin
      idle(1'b1);
      if (last_wb && last_wr == 3'd5) cnt_a++;
      if (k <= 4) chk("r5_age", 32'(ri[5]), 32'(k));
    end
    chk("r5_pulses", 32'(cnt_a), 32'd2);

    // flush with advance kills s1/s2 but keeps s3
    wr(3'd4);
    idle(1'b1);
    wr(3'd1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    chk("fl_r1", 32'(ri[1]), 32'd0);
    chk("fl_r4", 32'(ri[4]), 32'd4);
    cnt_a = 0; cnt_b = 0;
    repeat (3) begin
      idle(1'b1);
      if (last_wb && last_wr == 3'd4) cnt_a++;
      if (last_wb && last_wr == 3'd1) cnt_b++;
    end
    chk("fl_wb_r4", 32'(cnt_a), 32'd1);
    chk("fl_wb_r1", 32'(cnt_b), 32'd0);

    // frozen writeback is not repeated
    wr(3'd6);
    repeat (3) idle(1'b1);
    chk("r6_at_wb", 32'(ri[6]), 32'd4);
    repeat (3) begin
      idle(1'b0);
      chk("r6_frozen_wb", 32'(last_wb), 32'd0);
      chk("r6_frozen_ri", 32'(ri[6]), 32'd4);
    end
    idle(1'b1);
    chk("r6_wb", 32'(last_wb), 32'd1);
    idle(1'b1);
    chk("r6_wb_once", 32'(last_wb), 32'd0);

    // reset mid-pipeline discards everything
    wr(3'd0); wr(3'd1); wr(3'd2); wr(3'd7);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    chk("mid_rst_ri", 32'(dut_pack()), 32'd0);
    idle(1'b1);
    chk("mid_rst_wb", 32'(last_wb), 32'd0);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 49) == 0, $urandom_range(0, 4) != 0,
           $urandom_range(0, 9) == 0, 1'($urandom), 1'($urandom),
           3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/raw_scoreboard.md
RAW_SCOREBOARD -- requirements
Module: raw_scoreboard

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning), listed clock and reset first.
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 reset  in  1  reset, synchronous, active-high.
REQ-004 adv  in  1  pipeline advance; 0 = whole pipeline frozen.
REQ-005 flush  in  1  kill the instructions in slots s1 and s2 (branch taken in EX).
REQ-006 id_valid  in  1  decode holds a valid instruction.
REQ-007 id_we  in  1  the decode instruction writes a register.
REQ-008 id_rd  in  3  destination register of the decode instruction.
REQ-009 id_rs1, id_rs2  in  3 each  source registers of the decode instruction.
REQ-010 id_use1, id_use2  in  1 each  the corresponding source is actually read.
REQ-011 stall  out  1  decode must hold; the instruction is not issued.
REQ-012 register_invalid  out  8 x 3 (unpacked [7:0])  per-register pending-write stage, 0 = value in regfile is current.
REQ-013 wb_en  out  1  register-file write enable.
REQ-014 wb_wr  out  3  register-file write address.

Function
REQ-015 State SHALL be four slots s1..s4 (s4 = writeback); each slot holds {valid, we, rd[2:0]}.
REQ-016 Stall: id_valid & ((id_use1 & register_invalid[id_rs1] in 1..3) | (id_use2 & register_invalid[id_rs2] in 1..3)).
REQ-017 Value 4 SHALL never stall: the consumer bypasses from the writeback data.
REQ-018 An issue SHALL occur when adv & id_valid & !stall & !flush.
REQ-019 On adv with an issue: s1 <= {1, id_we, id_rd}, s2 <= s1, s3 <= s2, s4 <= s3.
REQ-020 On adv without an issue: s1 <= bubble (valid 0); s2..s4 shift as in REQ-019.
REQ-021 On adv=0 with flush=0: all slots hold; stall is still computed combinationally.
REQ-022 On flush & adv: s1, s2 and s3 <= bubble, and s4 <= s3; this kills old s1 and s2.
REQ-023 On flush & !adv: s1.valid <= 0 and s2.valid <= 0; s3 and s4 hold.
REQ-024 register_invalid[r] SHALL be the smallest k in 1..4 with sk.valid & sk.we & sk.rd == r, otherwise 0; the youngest write wins (WAW needs no stall).
REQ-025 register_invalid SHALL be combinational from the slots only, not from decode inputs.
REQ-026 wb_en SHALL equal s4.valid & s4.we & adv, so a frozen writeback is not repeated.
REQ-027 wb_wr SHALL equal s4.rd at all times.
REQ-028 A decode instruction reading a register it also writes SHALL be checked against older slots only, not against itself.

Reset
REQ-029 While reset = 1, all slot valid bits SHALL clear at the next rising edge; reset has priority over adv and flush.
REQ-030 After reset: register_invalid all 0, stall = 0, wb_en = 0, wb_wr = 0.
REQ-031 Reset asserted mid-pipeline SHALL discard all pending writes; no wb_en pulse follows.

Verification
REQ-032 Issue a write to r3, then adv each cycle; register_invalid[3] SHALL read 1, 2, 3, 4, 0 on successive cycles, with wb_en = 1 and wb_wr = 3 only on the cycle it reads 4.
REQ-033 A write to r2 followed immediately by an instruction reading r2 (id_use1 = 1) SHALL give stall = 1 for 3 cycles, then stall = 0 when register_invalid[2] = 4.
REQ-034 Writes to r5 issued on back-to-back cycles SHALL give register_invalid[5] = 1 while the older write sits in s2, then 2, 3, 4 for the younger write; wb_en SHALL pulse twice to r5.
REQ-035 With writes to r1 in s1 and r4 in s3, a flush together with adv SHALL make the next-cycle register_invalid[1] = 0 and register_invalid[4] = 4, with one wb_en to r4 and none to r1.
REQ-036 With adv held 0 for 3 cycles while s4 holds a write to r6: wb_en SHALL stay 0 and register_invalid[6] SHALL stay 4; on the first adv = 1, wb_en = 1 for exactly one cycle.
REQ-037 Reset asserted while all four slots hold valid writes SHALL give register_invalid all 0 and wb_en = 0 on the next cycle.
